gift_sbox_layer_seq: RTL and testbench

- Nibble-serial sequencer for the substitution layer of the 2-share threshold-masked GIFT-64 datapath.
- Sits directly upstream of the masked GIFT S-box. It accepts a 64-bit state as two Boolean shares and feeds one nibble per cycle, in bit-sliced share form, into the S-box's four 2-bit inputs.
- It collects the S-box's registered 2-share outputs and reassembles them into a 64-bit 2-share result for the permutation stage.
- Shares are never combined inside the block.

---
 rtl/gift_sbox_layer_seq_if.sv | 29 ++
 rtl/gift_sbox_layer_seq.sv | 175 +++++++++++++++++
 tb/tb_gift_sbox_layer_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gift_sbox_layer_seq_if.sv
// rtl/gift_sbox_layer_seq_if.sv - input/output share handshakes and S-box drive/return bus of gift_sbox_layer_seq
interface gift_sbox_layer_seq_if #(
  parameter int NIBBLES = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*NIBBLES-1:0] in_sh0;
  logic [4*NIBBLES-1:0] in_sh1;
  logic [1:0]           sb_a;
  logic [1:0]           sb_b;
  logic [1:0]           sb_c;
  logic [1:0]           sb_d;
  logic [3:0]           sb_y0;
  logic [3:0]           sb_y1;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*NIBBLES-1:0] out_sh0;
  logic [4*NIBBLES-1:0] out_sh1;

  modport slave (
    input  in_valid, in_sh0, in_sh1, sb_y0, sb_y1, out_ready,
    output in_ready, sb_a, sb_b, sb_c, sb_d, out_valid, out_sh0, out_sh1
  );

  modport master (
    output in_valid, in_sh0, in_sh1, sb_y0, sb_y1, out_ready,
    input  in_ready, sb_a, sb_b, sb_c, sb_d, out_valid, out_sh0, out_sh1
  );
endinterface

// File: rtl/gift_sbox_layer_seq.sv
// rtl/gift_sbox_layer_seq.sv - nibble-serial issue/capture sequencer for the 2-share masked GIFT-64 S-box layer
// Optional issue-time share refresh: define GIFT_SBOX_REFRESH_EN (adds i_rnd).
module gift_sbox_layer_seq #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef GIFT_SBOX_REFRESH_EN
  input  logic [3:0]           i_rnd,
`endif
  gift_sbox_layer_seq_if.slave bus,
  output logic                 o_busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int DW = (SBOX_LAT > 0) ? $clog2(SBOX_LAT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NIBBLES - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(SBOX_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_accept;
  logic          w_load;
  logic [3:0]    w_nib0;
  logic [3:0]    w_nib1;
  logic [3:0]    w_rnd;
  logic [IW-1:0] w_idx_nxt;

  logic [W-1:0]  r_sh0;
  logic [W-1:0]  r_sh1;
  logic [W-1:0]  r_out0;
  logic [W-1:0]  r_out1;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_drain;
  logic [3:0]    r_drv0;
  logic [3:0]    r_drv1;
  logic          r_tag_v   [SBOX_LAT];
  logic [IW-1:0] r_tag_idx [SBOX_LAT];

`ifdef GIFT_SBOX_REFRESH_EN
  assign w_rnd = i_rnd;
`else
  assign w_rnd = 4'h0;
`endif

  assign w_idx_nxt = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_load        = 1'b0;
    w_nib0        = 4'h0;
    w_nib1        = 4'h0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    o_busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        o_busy       = 1'b0;
        if (bus.in_valid) begin
          w_next   = S_ISSUE;
          w_accept = 1'b1;
          w_load   = 1'b1;
          w_nib0   = bus.in_sh0[3:0];
          w_nib1   = bus.in_sh1[3:0];
        end
      end
      S_ISSUE: begin
        if (r_idx == LAST_IDX) begin
          w_next = S_DRAIN;
        end else begin
          w_load = 1'b1;
          w_nib0 = r_sh0[{w_idx_nxt, 2'b00} +: 4];
          w_nib1 = r_sh1[{w_idx_nxt, 2'b00} +: 4];
        end
      end
      S_DRAIN: begin
        if (r_drain == LAST_DRAIN) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Drive registers hold the nibble the S-box sees this cycle; zero whenever nothing is issued.
  // With refresh, the same rnd is folded into both shares as the nibble is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_out0  <= '0;
      r_out1  <= '0;
      r_idx   <= '0;
      r_drain <= '0;
      r_drv0  <= 4'h0;
      r_drv1  <= 4'h0;
      for (int k = 0; k < SBOX_LAT; k++) begin
        r_tag_v[k]   <= 1'b0;
        r_tag_idx[k] <= '0;
      end
    end else begin
      r_drv0       <= w_load ? (w_nib0 ^ w_rnd) : 4'h0;
      r_drv1       <= w_load ? (w_nib1 ^ w_rnd) : 4'h0;
      r_tag_v[0]   <= (r_state == S_ISSUE);
      r_tag_idx[0] <= r_idx;
      for (int k = 1; k < SBOX_LAT; k++) begin
        r_tag_v[k]   <= r_tag_v[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end

      if (r_tag_v[SBOX_LAT-1]) begin
        r_out0[{r_tag_idx[SBOX_LAT-1], 2'b00} +: 4] <= bus.sb_y0;
        r_out1[{r_tag_idx[SBOX_LAT-1], 2'b00} +: 4] <= bus.sb_y1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh0 <= bus.in_sh0;
            r_sh1 <= bus.in_sh1;
            r_idx <= '0;
          end
        end
        S_ISSUE: begin
          r_idx   <= (r_idx == LAST_IDX) ? '0 : w_idx_nxt;
          r_drain <= '0;
        end
        S_DRAIN: begin
          if (w_next == S_DONE) begin
            r_drain <= '0;
            r_sh0   <= '0;
            r_sh1   <= '0;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sb_a    = {r_drv1[0], r_drv0[0]};
  assign bus.sb_b    = {r_drv1[1], r_drv0[1]};
  assign bus.sb_c    = {r_drv1[2], r_drv0[2]};
  assign bus.sb_d    = {r_drv1[3], r_drv0[3]};
  assign bus.out_sh0 = r_out0;
  assign bus.out_sh1 = r_out1;
endmodule

// File: tb/tb_gift_sbox_layer_seq.sv
// tb/tb_gift_sbox_layer_seq.sv - self-checking bench for gift_sbox_layer_seq with a 1-stage masked S-box model
module tb_gift_sbox_layer_seq;
  localparam int NIB    = 16;
  localparam int LAT    = 1;
  localparam int DONE_T = NIB + LAT + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  gift_sbox_layer_seq_if #(.NIBBLES(NIB)) bus ();

`ifdef GIFT_SBOX_REFRESH_EN
  logic [3:0] rnd = 4'h0;
  always begin
    @(posedge clk);
    #1 rnd = 4'($urandom);
  end
`endif

  gift_sbox_layer_seq #(.NIBBLES(NIB), .SBOX_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef GIFT_SBOX_REFRESH_EN
    .i_rnd (rnd),
`endif
    .bus   (bus),
    .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] gift_s(input logic [3:0] x);
    case (x)
      4'h0: return 4'h1;  4'h1: return 4'hA;  4'h2: return 4'h4;  4'h3: return 4'hC;
      4'h4: return 4'h6;  4'h5: return 4'hF;  4'h6: return 4'h3;  4'h7: return 4'h9;
      4'h8: return 4'h2;  4'h9: return 4'hD;  4'hA: return 4'hB;  4'hB: return 4'h7;
      4'hC: return 4'h5;  4'hD: return 4'h0;  4'hE: return 4'h8;  default: return 4'hE;
    endcase
  endfunction

  function automatic logic [63:0] sub_layer(input logic [63:0] v);
    logic [63:0] r;
    for (int k = 0; k < NIB; k++) r[4*k +: 4] = gift_s(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [3:0] drv_plain();
    return {bus.sb_d[1] ^ bus.sb_d[0], bus.sb_c[1] ^ bus.sb_c[0],
            bus.sb_b[1] ^ bus.sb_b[0], bus.sb_a[1] ^ bus.sb_a[0]};
  endfunction

  // Masked S-box stand-in: one register stage, output re-shared with a fresh mask
  logic [3:0] sb_mask = 4'h0;
  always @(negedge clk) sb_mask = 4'($urandom);
  always @(posedge clk) begin
    bus.sb_y0 <= sb_mask;
    bus.sb_y1 <= gift_s(drv_plain()) ^ sb_mask;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Cycle-position model: t counts cycles since the accepting edge
  bit          m_act = 1'b0;
  int          m_t   = 0;
  logic [63:0] m0, m1, last0, last1;
  bit          p_rst = 1'b1;
  bit          p_acc = 1'b0;
  bit          p_rel = 1'b0;
  logic [63:0] p0, p1;

  always @(negedge clk) begin
    logic [3:0] n0, n1;
    if (p_rst) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (m_act) begin
      if (p_rel) m_act = 1'b0;
      else       m_t++;
    end else if (p_acc) begin
      m_act = 1'b1;
      m_t   = 1;
      m0    = p0;
      m1    = p1;
    end

    if (p_rst) begin
      chk("rst_out_sh0", bus.out_sh0, 64'h0);
      chk("rst_out_sh1", bus.out_sh1, 64'h0);
    end
    chk("in_ready", 64'(bus.in_ready), 64'(!m_act));
    chk("busy", 64'(busy), 64'(m_act));
    chk("out_valid", 64'(bus.out_valid), 64'(m_act && m_t >= DONE_T));

    n0 = 4'h0;
    n1 = 4'h0;
    if (m_act && m_t >= 1 && m_t <= NIB) begin
      n0 = m0[4*(m_t-1) +: 4];
      n1 = m1[4*(m_t-1) +: 4];
    end
    chk("sb_plain", 64'(drv_plain()), 64'(n0 ^ n1));
`ifndef GIFT_SBOX_REFRESH_EN
    chk("sb_shares", 64'({bus.sb_d, bus.sb_c, bus.sb_b, bus.sb_a}),
        64'({n1[3], n0[3], n1[2], n0[2], n1[1], n0[1], n1[0], n0[0]}));
`endif

    if (m_act && m_t >= DONE_T) begin
      chk("out_plain", bus.out_sh0 ^ bus.out_sh1, sub_layer(m0 ^ m1));
      if (m_t > DONE_T) begin
        chk("hold_sh0", bus.out_sh0, last0);
        chk("hold_sh1", bus.out_sh1, last1);
      end
    end
    last0 = bus.out_sh0;
    last1 = bus.out_sh1;

    p_rst = !rst_n;
    p_acc = !m_act && bus.in_valid;
    p_rel = m_act && m_t >= DONE_T && bus.out_ready;
    p0    = bus.in_sh0;
    p1    = bus.in_sh1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] s0, input logic [63:0] s1);
    int n = 0;
    bus.in_sh0   = s0;
    bus.in_sh1   = s1;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("accept_wait", 64'(n < 100), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_sh0   = {$urandom, $urandom};
    bus.in_sh1   = {$urandom, $urandom};
  endtask

  task automatic collect(input logic [63:0] want, input int hold);
    int n = 1;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(DONE_T));
    chk("result", bus.out_sh0 ^ bus.out_sh1, want);
    repeat (hold) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h1A4C6F392DB7508E;
  localparam logic [63:0] MSK = 64'hDEADBEEFCAFEF00D;

  initial begin
    logic [63:0] s0, s1;
    int acc_cyc[$];
    int n;
    bus.in_valid  = 1'b0;
    bus.in_sh0    = 64'h0;
    bus.in_sh1    = 64'h0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sb", 64'({bus.sb_d, bus.sb_c, bus.sb_b, bus.sb_a}), 64'd0);
    rst_n = 1'b1;
    tick();

    chk("model_zero", sub_layer(64'h0), 64'h1111111111111111);
    chk("model_pt", sub_layer(PT), CT);

    start(64'h0, 64'h0);
    collect(64'h1111111111111111, 0);
    start(PT, 64'h0);
    collect(CT, 0);
    start(PT ^ MSK, MSK);
    collect(CT, 2);

    // Stalled consumer: result and in_ready frozen, next state waits for the IDLE cycle
    s0 = {$urandom, $urandom};
    s1 = {$urandom, $urandom};
    start(s0, s1);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("stall_result", bus.out_sh0 ^ bus.out_sh1, sub_layer(s0 ^ s1));
    s0 = {$urandom, $urandom};
    s1 = {$urandom, $urandom};
    bus.in_sh0   = s0;
    bus.in_sh1   = s1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("after_release_ready", 64'(bus.in_ready), 64'd1);
    chk("after_release_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("second_accepted", 64'(busy), 64'd1);
    collect(sub_layer(s0 ^ s1), 0);

    // Back-to-back with the consumer always ready
    bus.out_ready = 1'b1;
    bus.in_sh0    = {$urandom, $urandom};
    bus.in_sh1    = {$urandom, $urandom};
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 70; k++) begin
      if (bus.in_ready) acc_cyc.push_back(cyc);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("tput_count", 64'(acc_cyc.size() >= 3), 64'd1);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("tput_period", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(NIB + LAT + 2));
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("tput_drain", 64'(busy), 64'd0);
    bus.out_ready = 1'b0;

    // Abort at issue index 7
    start({$urandom, $urandom}, {$urandom, $urandom});
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_sh0", bus.out_sh0, 64'h0);
    repeat (25) tick();
    s1 = {$urandom, $urandom};
    start(PT ^ s1, s1);
    collect(CT, 0);

    for (int k = 0; k < 15; k++) begin
      s0 = {$urandom, $urandom};
      s1 = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) tick();
      start(s0, s1);
      collect(sub_layer(s0 ^ s1), $urandom_range(0, 4));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not reach its summary (checks %0d, failures %0d)", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
